spi_txn_ctrl: RTL and testbench
===============================

# spi_txn_ctrl

Transaction sequencer that sits between a byte-stream requester and the SPI master byte driver. It accepts one command describing a 1–16 byte full-duplex SPI transaction and pulses the driver's start. It feeds transmit bytes one at a time from the requester, returns each received byte, and requests end-of-transfer on the final byte. It enforces a minimum chip-select-high gap between transactions and aborts a stalled transfer with a watchdog.

## Interface

**Parameters**
- `GAP_CYCLES`, default 8: clk_1MHZ cycles spent in GAP after a transaction ends. Legal range 4..255.
- `TIMEOUT`, default 64: maximum clk_1MHZ cycles allowed between consecutive driver events in XFER. Legal range 40..1023.

**Ports**
- `clk_1MHZ` in 1: block clock. The driver's bit engine runs on the same clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: requester has a transaction.
- `cmd_ready` out 1: controller accepts a command. High only in IDLE.
- `cmd_len` in 4: byte count minus 1, so the transaction is cmd_len+1 bytes.
- `tx_rd` out 1: one-cycle pulse. tx_data is consumed in the same cycle. The requester advances to its next byte on the following cycle.
- `tx_data` in 8: next transmit byte, show-ahead.
- `rx_valid` out 1: one-cycle pulse, rx_data valid.
- `rx_data` out 8: received byte.
- `done` out 1: one-cycle pulse, transaction completed normally.
- `err` out 1: one-cycle pulse, transaction aborted by watchdog.
- `busy` out 1: high in any state other than IDLE.
- `spi_start` out 1: to driver, one-cycle start pulse.
- `spi_end` out 1: to driver, one-cycle end request.
- `data_send` out 8: to driver, byte currently being shifted.
- `send_done` in 1: from driver, pulses when the last bit of a byte is launched.
- `rec_done` in 1: from driver, pulses when a byte is fully received. data_rec is valid in the same cycle.
- `data_rec` in 8: from driver, received byte.

## Operation

**States:** IDLE, START, XFER, GAP.

**Reset values:** all outputs 0 (cmd_ready also 0 during reset), state IDLE, counters 0.
- cmd_ready rises on the first clock after reset release.

**IDLE**
- cmd_ready=1.
- On `cmd_valid` (accepted the same cycle):
  - latch len=cmd_len;
  - data_send<=tx_data and pulse tx_rd;
  - tx_cnt<=1, rx_cnt<=0;
  - go to START.

**START**
- spi_start=1 for exactly one cycle.
- Go to XFER and clear the watchdog.

**XFER**
- On `send_done`:
  - if tx_cnt<=len: data_send<=tx_data, tx_rd pulse, tx_cnt+1. The next byte is then registered within 1 cycle, well before the driver's next bit slot 4 cycles later.
  - else (final byte launched): pulse spi_end.
- On `rec_done`:
  - rx_data<=data_rec and pulse rx_valid;
  - rx_cnt+1;
  - if rx_cnt==len: pulse done and go to GAP.
- If send_done and rec_done occur in the same cycle, both are processed independently.
- **Watchdog:** counts cycles since the last send_done, rec_done, or START exit. On reaching TIMEOUT:
  - pulse spi_end and err (no done, no further rx_valid);
  - go to GAP.
- send_done or rec_done outside XFER is ignored.

**GAP**
- Count GAP_CYCLES, then return to IDLE.
- cmd_valid is not accepted here. The gap guarantees the driver has raised CS before the next spi_start.

**Counters**
- tx_cnt and rx_cnt are 5 bits and never wrap; the maximum is 16.
- data_send holds its last value outside XFER.

**Reset mid-transaction:** immediate return to IDLE with all outputs 0. A partially received byte is not reported.

## Timing

- Driver byte time is 32 clk_1MHZ cycles (8 bits × 4).
- From cmd accept: spi_start is high at +1 cycle; the first rx_valid arrives about 34 cycles later.
- Per-byte latency:
  - rx_valid and rx_data appear 1 cycle after rec_done;
  - tx_rd for byte k+1 fires in the cycle after send_done of byte k.
- done coincides with the final rx_valid.
- Back-to-back transactions: next cmd_ready rises GAP_CYCLES+1 cycles after done.
- A transaction of N bytes therefore occupies about 32N+GAP_CYCLES+3 cycles.
- spi_end fires exactly once per transaction: 1 cycle after the final send_done, or on timeout.

## Test plan

- **Single byte.** cmd_len=0, tx_data=0xA5, loopback MISO=MOSI.
  - Expect exactly one tx_rd, one spi_start, and one spi_end after the single send_done.
  - Expect rx_valid with rx_data=0xA5, done in the same cycle, then busy low after GAP_CYCLES+1 cycles.
- **16-byte burst.** cmd_len=15, tx stream 0x00..0x0F, loopback.
  - Expect 16 tx_rd pulses, 16 rx_valid with rx_data 0x00..0x0F in order, and one spi_end after the 16th send_done.
  - Expect done on the 16th rx_valid.
- **Back-to-back commands.** cmd_valid held high for two 2-byte commands.
  - Expect the second accept only in IDLE, at least GAP_CYCLES after the first done.
  - Expect no spi_start during GAP.
- **Watchdog.** Driver model stops emitting rec_done after the first byte of a 3-byte command.
  - Expect err and spi_end exactly TIMEOUT cycles after the last event, no done, a return to IDLE, and cmd_ready=1.
- **Reset mid-transfer.** Assert sys_rst_n low during byte 2 of 4.
  - Expect all outputs 0 asynchronously and no rx_valid after release.
  - Expect cmd_ready=1 one cycle after release.
- **Simultaneous events.** Inject send_done and rec_done in the same cycle in XFER.
  - Expect both tx_rd and rx_valid the next cycle, with counts correct.

Source files
------------

// File: rtl/spi_txn_ctrl.sv
// Sequences one 1..16 byte full-duplex SPI transaction for a byte driver:
// feeds tx bytes from a show-ahead requester, returns rx bytes, then holds a CS gap.
module spi_txn_ctrl #(
  parameter int GAP_CYCLES = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic       clk_1MHZ,
  input  logic       sys_rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_len,
  output logic       tx_rd,
  input  logic [7:0] tx_data,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       done,
  output logic       err,
  output logic       busy,
  output logic       spi_start,
  output logic       spi_end,
  output logic [7:0] data_send,
  input  logic       send_done,
  input  logic       rec_done,
  input  logic [7:0] data_rec
);

  typedef enum logic [1:0] {IDLE, START, XFER, GAP} state_e;

  localparam logic [9:0] WD_LAST  = 10'(TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] len_q, len_d;
  logic [4:0] tx_cnt_q, tx_cnt_d;
  logic [4:0] rx_cnt_q, rx_cnt_d;
  logic [9:0] wd_q, wd_d;
  logic [7:0] gap_q, gap_d;
  logic [7:0] data_send_q, data_send_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       tx_rd_q, tx_rd_d;
  logic       rx_valid_q, rx_valid_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       spi_end_q, spi_end_d;
  logic       end_sent_q, end_sent_d;
  logic       accept;
  logic       tx_rd_w;

  // The first byte is taken in the accept cycle so the driver has it by spi_start.
  assign accept  = cmd_valid & cmd_ready_q;
  assign tx_rd_w = accept | tx_rd_q;

  always_ff @(posedge clk_1MHZ or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      wd_q        <= '0;
      gap_q       <= '0;
      data_send_q <= '0;
      rx_data_q   <= '0;
      cmd_ready_q <= 1'b0;
      tx_rd_q     <= 1'b0;
      rx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      spi_end_q   <= 1'b0;
      end_sent_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      wd_q        <= wd_d;
      gap_q       <= gap_d;
      data_send_q <= data_send_d;
      rx_data_q   <= rx_data_d;
      cmd_ready_q <= cmd_ready_d;
      tx_rd_q     <= tx_rd_d;
      rx_valid_q  <= rx_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      spi_end_q   <= spi_end_d;
      end_sent_q  <= end_sent_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    wd_d        = wd_q;
    gap_d       = gap_q;
    data_send_d = data_send_q;
    rx_data_d   = rx_data_q;
    end_sent_d  = end_sent_q;
    tx_rd_d     = 1'b0;
    rx_valid_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    spi_end_d   = 1'b0;

    if (tx_rd_w) data_send_d = tx_data;

    case (state_q)
      IDLE: begin
        if (accept) begin
          len_d      = cmd_len;
          tx_cnt_d   = 5'd1;
          rx_cnt_d   = 5'd0;
          end_sent_d = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        wd_d    = 10'd1;
        state_d = XFER;
      end
      XFER: begin
        gap_d = '0;
        if (send_done) begin
          if (tx_cnt_q <= {1'b0, len_q}) begin
            tx_rd_d  = 1'b1;
            tx_cnt_d = tx_cnt_q + 5'd1;
          end else if (!end_sent_q) begin
            spi_end_d  = 1'b1;
            end_sent_d = 1'b1;
          end
        end
        if (rec_done) begin
          rx_data_d  = data_rec;
          rx_valid_d = 1'b1;
          if (rx_cnt_q <= {1'b0, len_q}) rx_cnt_d = rx_cnt_q + 5'd1;
          if (rx_cnt_q == {1'b0, len_q}) begin
            done_d  = 1'b1;
            state_d = GAP;
          end
        end
        // Any driver event restarts the watchdog; it only fires on a silent cycle.
        if (send_done || rec_done) begin
          wd_d = 10'd1;
        end else if (wd_q == WD_LAST) begin
          err_d      = 1'b1;
          spi_end_d  = !end_sent_q;
          end_sent_d = 1'b1;
          state_d    = GAP;
        end else begin
          wd_d = wd_q + 10'd1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  assign cmd_ready = cmd_ready_q;
  assign tx_rd     = tx_rd_w;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
  assign spi_start = (state_q == START);
  assign spi_end   = spi_end_q;
  assign data_send = data_send_q;

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Random and directed transactions against a loopback SPI driver model;
// a scoreboard of expected rx bytes is checked by a separate monitor.
module tb_spi_txn_ctrl;
  localparam int GAP = 8;
  localparam int TO  = 64;

  logic       clk_1MHZ = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_len = '0;
  logic [7:0] tx_data;
  logic       send_done = 1'b0, rec_done = 1'b0;
  logic [7:0] data_rec = '0;
  logic       cmd_ready, tx_rd, rx_valid, done, err, busy, spi_start, spi_end;
  logic [7:0] rx_data, data_send;

  spi_txn_ctrl #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk_1MHZ(clk_1MHZ), .sys_rst_n(sys_rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .tx_rd(tx_rd), .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data),
    .done(done), .err(err), .busy(busy), .spi_start(spi_start), .spi_end(spi_end),
    .data_send(data_send), .send_done(send_done), .rec_done(rec_done), .data_rec(data_rec)
  );

  always #5 clk_1MHZ = ~clk_1MHZ;

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk_1MHZ) cyc++;

  // Requester: show-ahead byte stream advancing after each tx_rd.
  logic [7:0] src [256];
  logic [7:0] tx_idx = '0;
  assign tx_data = src[tx_idx];
  always @(posedge clk_1MHZ) if (tx_rd) tx_idx <= tx_idx + 8'd1;

  // Driver: 32-cycle bytes, send_done at t=28, rec_done at t=rd_off, loopback.
  int   drv_t = 0, drv_n = 0, stall_after = 99, rd_off = 31;
  bit   drv_on = 0, end_seen = 0;
  logic [7:0] drv_byte = '0;
  initial forever begin
    @(posedge clk_1MHZ); #1;
    send_done = 1'b0; rec_done = 1'b0;
    if (!sys_rst_n) drv_on = 0;
    else if (drv_on) begin
      if (spi_end) end_seen = 1;
      drv_t++;
      if (drv_t == 32) begin
        if (end_seen) drv_on = 0;
        else begin drv_t = 0; drv_n++; drv_byte = data_send; end
      end
      if (drv_on && end_seen && drv_n >= stall_after) drv_on = 0;
      if (drv_on && drv_n < stall_after) begin
        if (drv_t == 28) send_done = 1'b1;
        if (drv_t == rd_off) begin rec_done = 1'b1; data_rec = drv_byte; end
      end
    end else if (spi_start) begin
      drv_on = 1; end_seen = 0; drv_t = 0; drv_n = 0; drv_byte = data_send;
    end
  end

  // Monitor / scoreboard
  logic [8:0] exp_q [$];
  int n_txrd, n_start, n_end, n_err, n_done, n_rx;
  int last_ev = -10000, end_cyc = -1, acc_cyc = -10000;
  bit prev_sd = 0, prev_rd = 0, prev_ready = 0;
  initial forever begin
    logic [8:0] e;
    @(negedge clk_1MHZ);
    if (!sys_rst_n) begin
      prev_sd = 0; prev_rd = 0; prev_ready = 0; end_cyc = -1;
      continue;
    end
    if (tx_rd)   n_txrd++;
    if (spi_end) n_end++;
    if (done)    n_done++;
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (spi_start) begin n_start++; chk("start_after_accept", cyc - acc_cyc, 1); end
    if (cmd_ready && !prev_ready && end_cyc >= 0) chk("ready_gap", cyc - end_cyc, GAP + 1);
    if (prev_sd) chk("txrd_xor_end_after_send_done", tx_rd ^ spi_end, 1);
    if (prev_rd) chk("rx_valid_after_rec_done", rx_valid, 1);
    if (done) chk("done_with_rx_valid", rx_valid, 1);
    if (rx_valid) begin
      n_rx++;
      chk("rx_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rx_data", rx_data, e[7:0]);
        chk("done_flag", done, e[8]);
      end
    end
    if (err) begin n_err++; chk("err_timing", cyc - last_ev, TO); end
    if (done || err) end_cyc = cyc;
    if (send_done || rec_done) last_ev = cyc;
    prev_sd = send_done; prev_rd = rec_done; prev_ready = cmd_ready;
  end

  task automatic clr_counts();
    n_txrd = 0; n_start = 0; n_end = 0; n_err = 0; n_done = 0; n_rx = 0;
  endtask

  task automatic issue(input int n, input int cnt);
    int t;
    @(posedge clk_1MHZ); #1;
    cmd_len = 4'(n - 1); cmd_valid = 1'b1;
    for (int k = 0; k < cnt; k++) begin
      t = 0;
      do begin @(negedge clk_1MHZ); t++; end while (!cmd_ready && t < 600);
      chk("accept_wait", cmd_ready, 1);
      @(posedge clk_1MHZ);
    end
    #1 cmd_valid = 1'b0;
  endtask

  // n bytes per command, cnt commands back-to-back, driver stalls after `stall` bytes.
  task automatic run(input int n, input int cnt, input int stall, input int roff, input int pat);
    int base, launched, t, txrd_exp;
    logic [7:0] b;
    clr_counts();
    stall_after = stall; rd_off = roff;
    base = tx_idx;
    launched = (stall < n) ? stall : n;
    for (int k = 0; k < cnt; k++)
      for (int i = 0; i < n; i++) begin
        b = (pat < 0) ? 8'($urandom) : 8'(pat + i);
        src[8'(base + k * n + i)] = b;
        if (i < launched) exp_q.push_back({(launched == n && i == n - 1), b});
      end
    issue(n, cnt);
    t = 0;
    do begin @(negedge clk_1MHZ); t++; end while (!cmd_ready && t < 3000);
    #1;
    chk("complete_wait", cmd_ready, 1);
    txrd_exp = 1 + ((launched < n - 1) ? launched : n - 1);
    chk("tx_rd_count", n_txrd, cnt * txrd_exp);
    chk("spi_start_count", n_start, cnt);
    chk("spi_end_count", n_end, cnt);
    chk("err_count", n_err, (launched < n) ? cnt : 0);
    chk("done_count", n_done, (launched < n) ? 0 : cnt);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic release_rst();
    @(posedge clk_1MHZ); #1 sys_rst_n = 1'b1;
    @(negedge clk_1MHZ); chk("ready_low_at_release", cmd_ready, 0);
    @(negedge clk_1MHZ); chk("ready_after_release", cmd_ready, 1);
  endtask

  task automatic reset_mid();
    int t;
    clr_counts();
    stall_after = 99; rd_off = 31;
    for (int i = 0; i < 4; i++) begin
      src[8'(tx_idx + 8'(i))] = 8'($urandom);
      if (i < 2) exp_q.push_back({1'b0, src[8'(tx_idx + 8'(i))]});
    end
    issue(4, 1);
    t = 0;
    while (!(drv_on && drv_n == 2 && drv_t == 10) && t < 1000) begin
      @(posedge clk_1MHZ); #2; t++;
    end
    chk("reached_byte2", drv_n, 2);
    @(negedge clk_1MHZ); #2 sys_rst_n = 1'b0;
    #1;
    chk("outputs_zero_mid_reset",
        {cmd_ready, tx_rd, rx_valid, rx_data, done, err, busy, spi_start, spi_end, data_send}, 0);
    chk("rx_before_reset", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk_1MHZ);
    n_rx = 0;
    release_rst();
    repeat (80) @(negedge clk_1MHZ);
    #1 chk("no_rx_after_reset", n_rx, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) src[i] = '0;
    #2;
    chk("outputs_zero_in_reset",
        {cmd_ready, tx_rd, rx_valid, rx_data, done, err, busy, spi_start, spi_end, data_send}, 0);
    repeat (3) @(posedge clk_1MHZ);
    release_rst();

    run(1, 1, 99, 31, 8'hA5);     // single byte
    run(16, 1, 99, 31, 0);        // 16-byte burst 0x00..0x0F
    run(2, 2, 99, 30, -1);        // back-to-back with cmd_valid held
    run(3, 1, 1, 31, -1);         // driver hangs after first byte
    run(4, 1, 99, 28, -1);        // send_done and rec_done coincide
    reset_mid();
    run(3, 1, 99, 31, -1);
    for (int r = 0; r < 10; r++)
      run(1 + int'($urandom_range(0, 15)), 1, 99, 28 + int'($urandom_range(0, 3)), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL global_timeout actual=%0d expected=finish", cyc);
    $fatal(1, "global timeout");
  end
endmodule
